// File: rtl/exu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// exu_wb_arbiter
//
// Shares the single register-file write port among the EXU result producers
// (index 0=ALU, 1=MUL, 2=DIV, 3=LSU). Each producer hands its result over
// through a valid/ready handshake into its own 1-entry hold buffer. A
// round-robin arbiter drains one occupied buffer per cycle onto a registered
// writeback bus that feeds the IDU1 register file and its WB forwarding path.
//
// Parameters
//   XLEN     data width of results and wb_data
//   NUM_SRC  number of producers
//
// Ports
//   clk          in   core clock
//   rst_n        in   asynchronous active-low reset
//   src_valid    in   [NUM_SRC]       producer i presents a result
//   src_data     in   [NUM_SRC*XLEN]  result of producer i, bits [i*XLEN +: XLEN]
//   src_rd_addr  in   [NUM_SRC*5]     destination register of producer i, bits [i*5 +: 5]
//   src_ready    out  [NUM_SRC]       hold buffer i can accept this cycle
//   wb_data      out  [XLEN]          writeback data (registered)
//   wb_rd_addr   out  [5]             writeback register index (registered)
//   wb_rd_wr_en  out                  writeback strobe, one cycle per write (registered)
//   wb_pending   out  [NUM_SRC]       hold buffer i occupied
//   wb_busy      out                  any hold buffer occupied
//
// Timing: a result accepted at edge C is granted at edge C+1 at the earliest,
// so wb_rd_wr_en is visible two cycles after src_valid was first presented.
// A buffer that is drained and refilled in the same cycle lets a lone
// producer sustain one result per cycle.
// -----------------------------------------------------------------------------
module exu_wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [NUM_SRC*5-1:0]    src_rd_addr,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic [XLEN-1:0]         wb_data,
  output logic [4:0]              wb_rd_addr,
  output logic                    wb_rd_wr_en,
  output logic [NUM_SRC-1:0]      wb_pending,
  output logic                    wb_busy
);

  localparam int              PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] hold_v;                 // buffer i holds a result
  logic [XLEN-1:0]    hold_data [NUM_SRC];    // buffered result payloads
  logic [4:0]         hold_rd   [NUM_SRC];    // buffered destination indices
  logic [PTR_W-1:0]   rr_ptr;                 // first index searched next cycle

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] grant;
  logic               any_grant;
  logic [PTR_W-1:0]   win_idx;

  // Search from rr_ptr upward with wrap-around; the first occupied buffer
  // wins. Only registered state is looked at, so grant never depends on
  // this cycle's src_valid.
  always_comb begin : arb_search
    logic [PTR_W-1:0] cand;
    // NOTE: every variable written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    grant     = '0;
    any_grant = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (!any_grant && hold_v[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        win_idx     = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] accept;

  // A buffer can take a new result when it is empty or is being drained this
  // cycle. rst_n is folded in so producers see ready low for the whole reset
  // window; with hold_v cleared, ready would otherwise read high.
  assign src_ready = (~hold_v | grant) & {NUM_SRC{rst_n}};
  assign accept    = src_valid & src_ready;

  // Occupancy: a grant empties the buffer, an accept (possibly in the same
  // cycle) fills it again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of block evaluation order.
      hold_v <= (hold_v & ~grant) | accept;
    end
  end

  // Payload loads only on accept.
  // NOTE: the payload arrays have no reset; they are only ever observed
  // through hold_v, which is reset, so clearing them would add reset fan-out
  // for no functional effect.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        hold_data[i] <= src_data[i*XLEN +: XLEN];
        hold_rd[i]   <= src_rd_addr[i*5 +: 5];
      end
    end
  end

  // Pointer moves to just past the winner; with no grant it holds so the
  // next occupied buffer in rotation order is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback register
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] win_data;
  logic [4:0]      win_rd;

  assign win_data = hold_data[win_idx];
  assign win_rd   = hold_rd[win_idx];

  // A granted x0 result still consumes its slot but produces no strobe, and
  // leaves data/addr untouched so the forwarding path keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data     <= '0;
      wb_rd_addr  <= '0;
      wb_rd_wr_en <= 1'b0;
    end else if (any_grant) begin
      wb_rd_wr_en <= (win_rd != 5'd0);
      if (win_rd != 5'd0) begin
        wb_data    <= win_data;
        wb_rd_addr <= win_rd;
      end
    end else begin
      wb_rd_wr_en <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign wb_pending = hold_v;
  assign wb_busy    = |hold_v;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exu_wb_arbiter
//
// Self-checking bench for exu_wb_arbiter. Each producer is fed from its own
// stimulus queue honouring valid/ready; expected writebacks are pushed to a
// scoreboard queue as stimulus is loaded and popped by a monitor on every
// wb_rd_wr_en pulse. Scenario tasks add their own cycle-exact checks.
// -----------------------------------------------------------------------------
module tb_exu_wb_arbiter;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 4;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } item_t;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_SRC-1:0]      src_valid;
  logic [NUM_SRC*XLEN-1:0] src_data;
  logic [NUM_SRC*5-1:0]    src_rd_addr;
  logic [NUM_SRC-1:0]      src_ready;
  logic [XLEN-1:0]         wb_data;
  logic [4:0]              wb_rd_addr;
  logic                    wb_rd_wr_en;
  logic [NUM_SRC-1:0]      wb_pending;
  logic                    wb_busy;

  exu_wb_arbiter #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_rd_addr (src_rd_addr),
    .src_ready   (src_ready),
    .wb_data     (wb_data),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_wr_en (wb_rd_wr_en),
    .wb_pending  (wb_pending),
    .wb_busy     (wb_busy)
  );

  int    vectors     = 0;
  int    miscompares = 0;
  item_t src_q [NUM_SRC][$];
  item_t exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every strobe must match the oldest expected write.
  initial begin
    item_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wb_rd_wr_en === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write", wb_rd_addr, wb_data);
        end else begin
          e = exp_q.pop_front();
          if (wb_rd_addr !== e.rd || wb_data !== e.data) begin
            miscompares++;
            $display("FAIL wb_scoreboard: got rd=%0d data=%h, expected rd=%0d data=%h",
                     wb_rd_addr, wb_data, e.rd, e.data);
          end
        end
      end
    end
  end

  // Present the head of each producer queue (or drop valid when empty).
  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_q[i].size() > 0) begin
        src_valid[i]             = 1'b1;
        src_data[i*XLEN +: XLEN] = src_q[i][0].data;
        src_rd_addr[i*5 +: 5]    = src_q[i][0].rd;
      end else begin
        src_valid[i]             = 1'b0;
        src_data[i*XLEN +: XLEN] = '0;
        src_rd_addr[i*5 +: 5]    = '0;
      end
    end
  endtask

  // One clock: sample the handshake before the edge, retire accepted items
  // after it, then re-drive. Returns at posedge + 1.
  task automatic step();
    logic [NUM_SRC-1:0] acc;
    @(negedge clk);
    acc = src_valid & src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++)
      if (acc[i]) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic load(input int src, input logic [4:0] rd, input logic [XLEN-1:0] data,
                      input bit expect_wb);
    item_t it;
    it.rd   = rd;
    it.data = data;
    src_q[src].push_back(it);
    if (expect_wb) exp_q.push_back(it);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d writes still outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1;
    drive();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (src_ready !== 4'h0) begin miscompares++; $display("FAIL rst_ready: got %b, expected 0000", src_ready); end
    vectors++;
    if (wb_pending !== 4'h0 || wb_busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_pending: got %b/%b, expected 0000/0", wb_pending, wb_busy);
    end
    vectors++;
    if (wb_rd_wr_en !== 1'b0 || wb_data !== '0 || wb_rd_addr !== '0) begin
      miscompares++;
      $display("FAIL rst_wb: got en=%b rd=%0d data=%h, expected 0/0/0", wb_rd_wr_en, wb_rd_addr, wb_data);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (src_ready !== 4'hF) begin miscompares++; $display("FAIL rst_release_ready: got %b, expected 1111", src_ready); end
  endtask

  task automatic test_alu_single();
    load(0, 5'd5, 32'h0000_1234, 1'b1);
    drive();
    step();
    vectors++;
    if (wb_pending !== 4'b0001 || wb_rd_wr_en !== 1'b0) begin
      miscompares++; $display("FAIL alu_accept: got pend=%b en=%b, expected 0001/0", wb_pending, wb_rd_wr_en);
    end
    step();
    vectors++;
    if (wb_rd_wr_en !== 1'b1 || wb_rd_addr !== 5'd5 || wb_data !== 32'h0000_1234 || wb_pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL alu_wb: got en=%b rd=%0d data=%h pend=%b, expected 1/5/00001234/0000",
               wb_rd_wr_en, wb_rd_addr, wb_data, wb_pending);
    end
    step();
    vectors++;
    if (wb_rd_wr_en !== 1'b0) begin miscompares++; $display("FAIL alu_single_pulse: got en=%b, expected 0", wb_rd_wr_en); end
  endtask

  task automatic test_all_four();
    logic [NUM_SRC-1:0] exp_ready;
    apply_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      load(i, 5'(i + 1), 32'h2000_0000 | (i + 1), 1'b1);
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      load(i, 5'(i + 5), 32'h2000_0000 | (i + 5), 1'b1);
    end
    drive();
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k <= 5) begin
        exp_ready = 4'b0001 << ((k - 1) % 4);
        vectors++;
        if (src_ready !== exp_ready) begin
          miscompares++; $display("FAIL all4_ready_%0d: got %b, expected %b", k, src_ready, exp_ready);
        end
      end
      vectors++;
      if (k >= 2 && k <= 9) begin
        if (wb_rd_wr_en !== 1'b1 || wb_rd_addr !== 5'(k - 1)) begin
          miscompares++;
          $display("FAIL all4_order_%0d: got en=%b rd=%0d, expected 1/%0d", k, wb_rd_wr_en, wb_rd_addr, k - 1);
        end
      end else if (wb_rd_wr_en !== 1'b0) begin
        miscompares++; $display("FAIL all4_idle_%0d: got en=%b, expected 0", k, wb_rd_wr_en);
      end
    end
    drain("all4");
  endtask

  task automatic test_alu_stream();
    for (int r = 1; r <= 8; r++) load(0, 5'(r), 32'hA000_0000 + r, 1'b1);
    drive();
    for (int k = 1; k <= 10; k++) begin
      step();
      vectors++;
      if (src_ready[0] !== 1'b1) begin
        miscompares++; $display("FAIL stream_ready_%0d: got %b, expected 1", k, src_ready[0]);
      end
      vectors++;
      if (wb_rd_wr_en !== ((k >= 2 && k <= 9) ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL stream_pulse_%0d: got en=%b, expected %b", k, wb_rd_wr_en, (k >= 2 && k <= 9));
      end
    end
    drain("stream");
  endtask

  task automatic test_x0_write();
    load(1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    drive();
    step();
    vectors++;
    if (wb_pending !== 4'b0010 || wb_busy !== 1'b1) begin
      miscompares++; $display("FAIL x0_pending: got %b/%b, expected 0010/1", wb_pending, wb_busy);
    end
    step();
    vectors++;
    if (wb_pending !== 4'b0000 || wb_rd_wr_en !== 1'b0) begin
      miscompares++; $display("FAIL x0_granted: got pend=%b en=%b, expected 0000/0", wb_pending, wb_rd_wr_en);
    end
    vectors++;
    if (wb_data !== 32'hA000_0008 || wb_rd_addr !== 5'd8) begin
      miscompares++; $display("FAIL x0_hold: got rd=%0d data=%h, expected 8/a0000008", wb_rd_addr, wb_data);
    end
    step();
    vectors++;
    if (wb_rd_wr_en !== 1'b0) begin miscompares++; $display("FAIL x0_no_pulse: got en=%b, expected 0", wb_rd_wr_en); end
  endtask

  task automatic test_fairness();
    int cnt [NUM_SRC];
    int src;
    apply_reset();
    for (int i = 0; i < NUM_SRC; i++) cnt[i] = 0;
    // rd = 1 + src + 4*j, so rotation 0,1,2,3 yields rd 1..20 in order.
    for (int j = 0; j < 5; j++)
      for (int i = 0; i < NUM_SRC; i++)
        load(i, 5'(1 + i + 4 * j), 32'h5000_0000 + (1 + i + 4 * j), 1'b1);
    drive();
    step();
    for (int k = 0; k < 12; k++) begin
      step();
      vectors++;
      if (wb_rd_wr_en !== 1'b1) begin
        miscompares++; $display("FAIL fair_pulse_%0d: got en=%b, expected 1", k, wb_rd_wr_en);
      end else if (wb_rd_addr != 5'd0) begin
        src = (int'(wb_rd_addr) - 1) % NUM_SRC;
        cnt[src]++;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      vectors++;
      if (cnt[i] != 3) begin miscompares++; $display("FAIL fair_count_%0d: got %0d grants, expected 3", i, cnt[i]); end
    end
    drain("fair");
  endtask

  task automatic test_reset_midop();
    // Move rr_ptr away from 0 first (grant to 1 -> rr_ptr=2).
    load(1, 5'd25, 32'h6000_0019, 1'b1);
    drive();
    step();
    step();
    load(0, 5'd26, 32'h6000_001A, 1'b0);
    load(1, 5'd27, 32'h6000_001B, 1'b0);
    load(2, 5'd28, 32'h6000_001C, 1'b1);
    load(3, 5'd29, 32'h6000_001D, 1'b0);
    drive();
    step();
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    drive();
    step();
    #1;
    vectors++;
    if (wb_pending !== 4'b1011 || wb_rd_wr_en !== 1'b1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL midop_setup: got pend=%b en=%b outstanding=%0d, expected 1011/1/0",
               wb_pending, wb_rd_wr_en, exp_q.size());
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (wb_rd_wr_en !== 1'b0 || wb_pending !== 4'b0000 || wb_busy !== 1'b0 || src_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL midop_reset: got en=%b pend=%b busy=%b ready=%b, expected 0/0000/0/0000",
               wb_rd_wr_en, wb_pending, wb_busy, src_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (wb_rd_wr_en !== 1'b0 || wb_pending !== 4'b0000) begin
        miscompares++; $display("FAIL midop_stale_%0d: got en=%b pend=%b, expected 0/0000", k, wb_rd_wr_en, wb_pending);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) load(i, 5'(i + 1), 32'h7000_0000 | (i + 1), 1'b1);
    drive();
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (wb_rd_wr_en !== 1'b1 || wb_rd_addr !== 5'(k)) begin
        miscompares++; $display("FAIL midop_rr_restart_%0d: got en=%b rd=%0d, expected 1/%0d", k, wb_rd_wr_en, wb_rd_addr, k);
      end
    end
    drain("midop");
  endtask

  initial begin
    rst_n       = 1'b1;
    src_valid   = '0;
    src_data    = '0;
    src_rd_addr = '0;
    test_reset();
    test_alu_single();
    test_all_four();
    test_alu_stream();
    test_x0_write();
    test_fairness();
    test_reset_midop();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
